// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: clock rate, default and
// simulation cycle constants, and the per-channel state encoding.
package key_debounce_pkg;

    localparam int unsigned CLK_HZ          = 32'd12_000_000;

    // 20 ms of stable samples and a 1 s hold at CLK_HZ.
    localparam int unsigned DB_CYCLES_DEF   = CLK_HZ / 32'd50;
    localparam int unsigned LONG_CYCLES_DEF = CLK_HZ;

    // Short constants so simulations finish in a few hundred cycles.
    localparam int unsigned DB_CYCLES_SIM   = 32'd4;
    localparam int unsigned LONG_CYCLES_SIM = 32'd16;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } kdb_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, press/release FSM with a
// stability counter, and a saturating hold counter for long-press detection.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_n_i    raw active-low key, asynchronous to clk
//   level_o    debounced level, 1 = pressed
//   press_o    1-cycle pulse on debounced press
//   release_o  1-cycle pulse on debounced release
//   long_o     1-cycle pulse once per press after LONG_CYCLES held
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic              sync1_q, sync2_q;
    kdb_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // Synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RELEASED;
            db_cnt_q   <= DB_ZERO;
            hold_cnt_q <= HOLD_ZERO;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    // Next-state and pulse generation; only sync2_q is ever sampled.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (!sync2_q) begin
                    // The first low sample already counts as one stable sample.
                    state_d  = ST_PRESS_CHK;
                    db_cnt_d = DB_ONE;
                end else begin
                    db_cnt_d = DB_ZERO;
                end
            end
            ST_PRESS_CHK: begin
                if (sync2_q) begin
                    state_d  = ST_RELEASED;
                    db_cnt_d = DB_ZERO;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = ST_PRESSED;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = HOLD_ZERO;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            ST_PRESSED: begin
                if (sync2_q) begin
                    state_d  = ST_RELEASE_CHK;
                    db_cnt_d = DB_ONE;
                end else begin
                    // Saturation past LONG_CYCLES-1 keeps key_long to one pulse per press.
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d = 1'b1;
                    end else begin
                        long_d = 1'b0;
                    end
                end
            end
            ST_RELEASE_CHK: begin
                if (!sync2_q) begin
                    // Release bounce: resume the press with hold_cnt intact.
                    state_d = ST_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    db_cnt_d  = DB_ZERO;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d    = ST_RELEASED;
                db_cnt_d   = DB_ZERO;
                hold_cnt_d = HOLD_ZERO;
                level_d    = 1'b0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Input conditioning for N_KEYS raw active-low push keys: each key is
// synchronised and debounced independently, producing clean levels and
// single-cycle press / release / long-press pulses.
// Ports:
//   clk          system clock (12 MHz)
//   rst_n        asynchronous active-low reset
//   key_n        raw keys, 0 = pressed, asynchronous to clk
//   key_level    debounced level per key, 1 = pressed
//   key_press    1-cycle pulse per key on debounced press
//   key_release  1-cycle pulse per key on debounced release
//   key_long     1-cycle pulse per key, once per press, after LONG_CYCLES held
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS      = 32'd4,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n_i   (key_n[g]),
            .level_o   (key_level[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g]),
            .long_o    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce with DB_CYCLES=4, LONG_CYCLES=16.
// The reference model treats each key as a stream of samples delayed by two
// clocks; the level flips when the last DB_CYCLES samples all disagree with it,
// and a long pulse fires when the count of held samples since the press hits
// LONG_CYCLES.
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int DB = int'(DB_CYCLES_SIM);
    localparam int LG = int'(LONG_CYCLES_SIM);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'b0000;
    logic [3:0] key_level, key_press, key_release, key_long;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int press_seen [4] = '{default: 0};
    int rel_seen   [4] = '{default: 0};
    int long_seen  [4] = '{default: 0};

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS      (32'd4),
        .DB_CYCLES   (DB_CYCLES_SIM),
        .LONG_CYCLES (LONG_CYCLES_SIM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    // ---------------- reference model ----------------
    logic [3:0] hist_m [0:DB+1];   // hist_m[0] = newest key_n sample
    logic [3:0] lvl_m, prs_m, rel_m, lng_m;
    logic [3:0] win0_m, win1_m;
    int         hold_m [4];

    // Window of the DB samples the debouncer is currently judging.
    always_comb begin
        win0_m = 4'b1111;
        win1_m = 4'b1111;
        for (int i = 1; i <= DB; i++) begin
            win0_m = win0_m & ~hist_m[i];
            win1_m = win1_m & hist_m[i];
        end
    end

    // Model state update.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DB + 2; i++) hist_m[i] <= 4'b1111;
            lvl_m <= 4'b0000;
            prs_m <= 4'b0000;
            rel_m <= 4'b0000;
            lng_m <= 4'b0000;
            for (int k = 0; k < 4; k++) hold_m[k] <= 0;
        end else begin
            hist_m[0] <= key_n;
            for (int i = 1; i < DB + 2; i++) hist_m[i] <= hist_m[i-1];
            prs_m <= 4'b0000;
            rel_m <= 4'b0000;
            lng_m <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                if (!lvl_m[k] && win0_m[k]) begin
                    lvl_m[k]  <= 1'b1;
                    prs_m[k]  <= 1'b1;
                    hold_m[k] <= 0;
                end else if (lvl_m[k] && win1_m[k]) begin
                    lvl_m[k] <= 1'b0;
                    rel_m[k] <= 1'b1;
                end else if (lvl_m[k] && !hist_m[1][k] && !hist_m[2][k]) begin
                    hold_m[k] <= hold_m[k] + 1;
                    if (hold_m[k] + 1 == LG) lng_m[k] <= 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check4("model_level",   key_level,   lvl_m);
        check4("model_press",   key_press,   prs_m);
        check4("model_release", key_release, rel_m);
        check4("model_long",    key_long,    lng_m);
    end

    // Pulse tallies.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            press_seen[k] <= press_seen[k] + int'(key_press[k]);
            rel_seen[k]   <= rel_seen[k]   + int'(key_release[k]);
            long_seen[k]  <= long_seen[k]  + int'(key_long[k]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Keys held low across reset release.
        step(3);
        check4("rst_level",   key_level,   4'b0000);
        check4("rst_press",   key_press,   4'b0000);
        check4("rst_release", key_release, 4'b0000);
        check4("rst_long",    key_long,    4'b0000);
        rst_n = 1'b1;
        step(5);
        check4("t1_press_e5", key_press, 4'b0000);
        step(1);
        check4("t1_press_e6", key_press, 4'b1111);
        check4("t1_level_e6", key_level, 4'b1111);
        step(1);
        check4("t1_press_e7", key_press, 4'b0000);
        check4("t1_level_e7", key_level, 4'b1111);
        key_n = 4'b1111;
        step(6);
        check4("t1_release_e6", key_release, 4'b1111);
        step(4);
        check4("t1_level_rel", key_level, 4'b0000);

        // 2. Short glitch on key 1.
        key_n[1] = 1'b0;
        step(3);
        key_n[1] = 1'b1;
        step(10);
        check4("t2_level", key_level, 4'b0000);
        check_int("t2_press_cnt1", press_seen[1], 1);
        check_int("t2_rel_cnt1",   rel_seen[1],   1);

        // 3. Clean press and release on key 0.
        key_n[0] = 1'b0;
        step(5);
        check4("t3_press_e5", key_press, 4'b0000);
        step(1);
        check4("t3_press_e6", key_press, 4'b0001);
        check4("t3_level_e6", key_level, 4'b0001);
        step(1);
        check4("t3_press_e7", key_press, 4'b0000);
        step(13);
        key_n[0] = 1'b1;
        step(5);
        check4("t3_release_e5", key_release, 4'b0000);
        step(1);
        check4("t3_release_e6", key_release, 4'b0001);
        step(1);
        check4("t3_release_e7", key_release, 4'b0000);
        check4("t3_level_after", key_level, 4'b0000);
        step(3);
        check_int("t3_press_cnt0", press_seen[0], 2);
        check_int("t3_rel_cnt0",   rel_seen[0],   2);

        // 4. Long press on key 2.
        key_n[2] = 1'b0;
        step(6);
        check4("t4_press_e6", key_press, 4'b0100);
        step(15);
        check4("t4_long_e21", key_long, 4'b0000);
        step(1);
        check4("t4_long_e22", key_long, 4'b0100);
        step(1);
        check4("t4_long_e23", key_long, 4'b0000);
        step(18);
        check_int("t4_long_cnt2", long_seen[2], 1);
        key_n[2] = 1'b1;
        step(10);
        check_int("t4_rel_cnt2", rel_seen[2], 2);

        // 5. Release bounce on a pressed key 0.
        key_n[0] = 1'b0;
        step(8);
        check4("t5_level_pressed", key_level, 4'b0001);
        key_n[0] = 1'b1;
        step(2);
        key_n[0] = 1'b0;
        step(10);
        check4("t5_level_hold", key_level, 4'b0001);
        check_int("t5_press_cnt0", press_seen[0], 3);
        check_int("t5_rel_cnt0",   rel_seen[0],   2);
        key_n[0] = 1'b1;
        step(10);
        check_int("t5_rel_cnt0_end", rel_seen[0], 3);

        // 6. Reset while key 3 is pressed.
        key_n[3] = 1'b0;
        step(8);
        check4("t6_level_pressed", key_level, 4'b1000);
        rst_n = 1'b0;
        #1;
        check4("t6_level_async", key_level, 4'b0000);
        step(3);
        key_n = 4'b1111;
        rst_n = 1'b1;
        step(12);
        check4("t6_level_end", key_level, 4'b0000);
        check_int("t6_rel_cnt3",   rel_seen[3],   1);
        check_int("t6_press_cnt3", press_seen[3], 2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
